// File: rtl/eight_data_decompress_unit_if.sv
// Bus bundle for the eight-lane decompress unit.
// Advance semantics: wrtEn is a global pipeline enable rather than a
// valid/ready pair. A beat on the input side is captured on a rising edge
// only when wrtEn=1; with wrtEn=0 every stage holds and the presented beat
// is dropped. flags_in[3] marks a beat as valid, so wrtEn=1 with valid=0
// pushes a bubble. There is no backpressure path toward the source.
interface eight_data_decompress_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_UNITS  = 8,
  parameter int TAG_WIDTH  = 2,
  parameter int LEN_WIDTH  = 8
);
  logic                             wrtEn;
  logic [3:0]                       flags_in;
  logic [DATA_WIDTH*NUM_UNITS-1:0]  dataIn;
  logic [TAG_WIDTH*NUM_UNITS-1:0]   tagIn;
  logic [LEN_WIDTH-1:0]             lenIn;
  logic [DATA_WIDTH*NUM_UNITS-1:0]  dataOut;
  logic [3:0]                       flags_out;
  logic                             len_err;
  logic                             err_sticky;
  logic [15:0]                      pkt_cnt;

  modport master (
    output wrtEn, flags_in, dataIn, tagIn, lenIn,
    input  dataOut, flags_out, len_err, err_sticky, pkt_cnt
  );

  modport slave (
    input  wrtEn, flags_in, dataIn, tagIn, lenIn,
    output dataOut, flags_out, len_err, err_sticky, pkt_cnt
  );
endinterface

// File: rtl/eight_data_decompress_unit.sv
// Eight-lane decompressor: rebuilds eight 32-bit words from a byte-packed
// payload using 2-bit size tags. Stage 1 registers the beat with per-lane
// byte offsets and the length check; stage 2 extracts the lanes.
// Headers, uncompressed beats and bubbles bypass the extraction.
module eight_data_decompress_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_UNITS  = 8,
  parameter int TAG_WIDTH  = 2,
  parameter int LEN_WIDTH  = 8
) (
  input logic clk,
  input logic reset,
  eight_data_decompress_unit_if.slave bus
);
  localparam int BUS_W = DATA_WIDTH * NUM_UNITS;
  localparam int LANE_BYTES = DATA_WIDTH / 8;

  // Tag to byte count: 00->0, 01->1, 10->2, 11->4.
  function automatic logic [2:0] tag_size(input logic [TAG_WIDTH-1:0] t);
    case (t)
      2'b00:   tag_size = 3'd0;
      2'b01:   tag_size = 3'd1;
      2'b10:   tag_size = 3'd2;
      default: tag_size = 3'd4;
    endcase
  endfunction

  // Lane offsets before lane 7 never exceed 28, so 5 bits hold them;
  // the running total reaches 32 and needs 6.
  logic [4:0] off [NUM_UNITS];
  logic [5:0] total;
  logic       decode;
  logic       mismatch;

  // Prefix-sum the lane sizes into byte offsets and the payload total.
  always_comb begin
    logic [5:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      off[i] = acc[4:0];
      acc = acc + 6'(tag_size(bus.tagIn[TAG_WIDTH*i +: TAG_WIDTH]));
    end
    total = acc;
  end

  assign decode   = bus.flags_in[3] & bus.flags_in[1] & ~bus.flags_in[0];
  assign mismatch = decode && (bus.lenIn != LEN_WIDTH'(total));

  logic [BUS_W-1:0]               s1_data;
  logic [3:0]                     s1_flags;
  logic [TAG_WIDTH*NUM_UNITS-1:0] s1_tag;
  logic [4:0]                     s1_off [NUM_UNITS];
  logic                           s1_decode;
  logic                           s1_mismatch;

  // Stage 1: capture the beat together with offsets and length verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_data     <= '0;
      s1_flags    <= '0;
      s1_tag      <= '0;
      s1_off      <= '{default: '0};
      s1_decode   <= 1'b0;
      s1_mismatch <= 1'b0;
    end else if (bus.wrtEn) begin
      s1_data     <= bus.dataIn;
      s1_flags    <= bus.flags_in;
      s1_tag      <= bus.tagIn;
      s1_off      <= off;
      s1_decode   <= decode;
      s1_mismatch <= mismatch;
    end
  end

  logic [BUS_W-1:0] extracted;
  logic [BUS_W-1:0] next_data;

  // Pull each lane's bytes out of the packed payload, zero-extended.
  // Bytes beyond a lane's size stay zero, so unused payload is ignored.
  always_comb begin
    logic [2:0] sz;
    extracted = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      sz = tag_size(s1_tag[TAG_WIDTH*i +: TAG_WIDTH]);
      for (int b = 0; b < LANE_BYTES; b++) begin
        if (3'(b) < sz) begin
          extracted[DATA_WIDTH*i + 8*b +: 8] =
            s1_data[{s1_off[i] + 5'(b), 3'b000} +: 8];
        end
      end
    end
  end

  // Bubbles output zero; non-decoded valid beats pass through untouched.
  always_comb begin
    next_data = '0;
    if (s1_flags[3]) begin
      next_data = s1_decode ? extracted : s1_data;
    end
  end

  logic [BUS_W-1:0] data_q;
  logic [3:0]       flags_q;
  logic             len_err_q;
  logic             sticky_q;
  logic [15:0]      cnt_q;

  // Stage 2: register outputs, accumulate sticky error and packet count.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      flags_q   <= '0;
      len_err_q <= 1'b0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
    end else if (bus.wrtEn) begin
      data_q    <= next_data;
      flags_q   <= s1_flags;
      len_err_q <= s1_mismatch;
      sticky_q  <= sticky_q | s1_mismatch;
      if (s1_flags[3] && s1_flags[2]) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign bus.dataOut    = data_q;
  assign bus.flags_out  = flags_q;
  assign bus.len_err    = len_err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.pkt_cnt    = cnt_q;
endmodule

// File: doc/eight_data_decompress_unit.md
Name: eight_data_decompress_unit

Overview:
- Inverse of the eight-lane compress unit.
- Takes one packed compressed beat per cycle: 256-bit byte-packed payload, 2-bit tag per lane, byte length and 4-bit flags.
- Reconstructs eight 32-bit words over a 2-stage pipeline.
- Sits on the receive/decompression path ahead of the stream output; headers and uncompressed beats pass through unchanged.

Parameters:
- DATA_WIDTH, 32, width of one lane word
- NUM_UNITS, 8, number of lanes per beat
- TAG_WIDTH, 2, tag bits per lane
- LEN_WIDTH, 8, width of payload byte-count field

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- wrtEn  input  1  pipeline advance enable; 0 stalls both stages
- flags_in  input  4  [3] valid, [2] tlast, [1] flag_compression, [0] is_header
- dataIn  input  256  packed payload; byte k = dataIn[8k+7:8k]
- tagIn  input  16  lane i tag = tagIn[2i+1:2i]
- lenIn  input  8  payload byte count from compressor
- dataOut  output  256  reconstructed words; lane i = dataOut[32i+31:32i]
- flags_out  output  4  flags_in delayed through the pipeline
- len_err  output  1  current output beat failed the length check
- err_sticky  output  1  latched OR of len_err; cleared only by reset
- pkt_cnt  output  16  count of valid tlast beats emitted

Behaviour:
Tag sizes:
- 00 = 0 bytes; word is 0.
- 01 = 1 byte, zero-extended.
- 10 = 2 bytes, zero-extended.
- 11 = 4 bytes, raw.

Decode rules:
- A beat is decoded when flags_in[3]=1, flags_in[1]=1 and flags_in[0]=0.
- Otherwise dataIn passes to dataOut unchanged and tagIn/lenIn are ignored.

Stage 1 (registered when wrtEn=1):
- Captures dataIn, flags_in, tagIn.
- Computes 6-bit offsets off_i = sum of size(tag_j) for j<i; off_0 = 0.
- Computes total = off_7 + size(tag_7), range 0..32.
- Registers mismatch = decode && (lenIn != total), compared at 8 bits.

Stage 2 (registered when wrtEn=1):
- For decoded beats, lane i = bytes off_i .. off_i+size_i-1, little-endian (byte off_i in bits [7:0]), zero-extended to 32 bits.
- Tag 00 lanes output 0.
- Bytes of dataIn above total are ignored.
- flags_out takes the stage-1 flags.
- len_err takes mismatch.
- err_sticky |= mismatch.

Latency and stalls:
- Latency is exactly 2 rising edges with wrtEn=1.
- wrtEn=0: every register holds, including pkt_cnt and err_sticky. Input presented during a stall is dropped.
- Stall on the same cycle as a beat: that beat is not captured.

Invalid beats:
- A beat with flags_in[3]=0 propagates as a bubble.
- Its dataOut = 0, flags_out = flags_in value, len_err = 0.

pkt_cnt:
- Increments by 1 on the edge where stage 2 loads a beat with valid=1 and tlast=1 under wrtEn=1.
- Wraps FFFF -> 0000.
- Header beats with tlast also count.

Reset:
- Synchronous reset has priority over wrtEn.
- Clears both stages: dataOut = 0, flags_out = 0, len_err = 0, err_sticky = 0, pkt_cnt = 0.
- Beats in flight are discarded; the first output after reset deasserts appears 2 enabled edges after the first captured beat.

Length mismatch:
- Output data is still produced from tags.
- lenIn is only checked, never used for extraction.

Test Plan:
- Reset: hold reset high for 2 edges with valid stimulus -> dataOut = 0, flags_out = 0, pkt_cnt = 0, len_err = 0, err_sticky = 0.
- Header passthrough: flags_in = 1011, dataIn = {16{16'hBA98_FEDC}} pattern, tagIn = 0 -> after 2 edges dataOut equals dataIn, flags_out = 1011, len_err = 0.
- All full: flags_in = 1010, tagIn = FFFF, lenIn = 32, dataIn = 0x0F0E..0100 byte ramp -> dataOut = dataIn, len_err = 0.
- Mixed: flags_in = 1010, tagIn = 16'h00E4, lenIn = 7, dataIn[55:0] = 56'hDEADBEEF_1234_AB, upper bytes = FF.
  - Expected: lane0 = 0, lane1 = 000000AB, lane2 = 00001234, lane3 = DEADBEEF, lanes 4-7 = 0.
- Length error: repeat the mixed beat with lenIn = 8 -> identical dataOut, len_err = 1 on that output beat only; err_sticky = 1 until reset.
- Stall + tlast: stream 3 beats with the last at flags 1110; drop wrtEn for 3 cycles while the tlast beat is in stage 2.
  - Outputs hold; pkt_cnt increments exactly once, to 1.
  - Beats presented during the stall never appear at the output.
